// File: rtl/serial_tx_if.sv
// serial_tx_if: host-side byte write/flow-control bundle plus serial line for serial_tx
interface serial_tx_if;
  logic       block;
  logic [7:0] data;
  logic       new_data;
  logic       tx;
  logic       busy;
  modport master (output block, data, new_data, input tx, busy);
  modport slave  (input block, data, new_data, output tx, busy);
endinterface

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter with one-byte holding register; define SERIAL_TX_PARITY_EN for 8E1/8E2
module serial_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = 6,
  parameter int STOP_BITS   = 1
) (
  input logic         clk,
  input logic         rst,
  serial_tx_if.slave  s
);
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS, STOP_BIT
`ifdef SERIAL_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t              state;
  logic [CTR_SIZE-1:0] ctr;
  logic [2:0]          bit_ctr;
  logic [7:0]          shift;
  logic [7:0]          hold;
  logic                tx_r;
  logic                busy_r;
  logic                ctr_end;
  logic                last_stop;
  logic                launch;
`ifdef SERIAL_TX_PARITY_EN
  logic                par;
`endif
  assign s.tx   = tx_r;
  assign s.busy = busy_r;
  // launch points: idle, or the final cycle of the last stop bit
  always_comb begin
    ctr_end   = ctr == CTR_SIZE'(CLK_PER_BIT - 1);
    last_stop = bit_ctr == 3'(STOP_BITS - 1);
    launch    = busy_r && !s.block && (state == IDLE || (state == STOP_BIT && ctr_end && last_stop));
  end
  // frame sequencer, holding register and registered line output
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ctr     <= '0;
      bit_ctr <= '0;
      shift   <= '0;
      hold    <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      if (s.new_data && !busy_r) begin
        hold   <= s.data;
        busy_r <= 1'b1;
      end
      ctr <= (state == IDLE || ctr_end) ? '0 : ctr + 1'b1;
      case (state)
        IDLE: tx_r <= 1'b1;
        START_BIT: if (ctr_end) begin
          state <= DATA_BITS;
          tx_r  <= shift[0];
          shift <= shift >> 1;
        end
        DATA_BITS: if (ctr_end) begin
          if (bit_ctr == 3'd7) begin
            bit_ctr <= '0;
`ifdef SERIAL_TX_PARITY_EN
            state   <= PARITY;
            tx_r    <= par;
`else
            state   <= STOP_BIT;
            tx_r    <= 1'b1;
`endif
          end else begin
            bit_ctr <= bit_ctr + 1'b1;
            tx_r    <= shift[0];
            shift   <= shift >> 1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: if (ctr_end) begin
          state <= STOP_BIT;
          tx_r  <= 1'b1;
        end
`endif
        STOP_BIT: begin
          tx_r <= 1'b1;
          if (ctr_end) begin
            bit_ctr <= last_stop ? '0 : bit_ctr + 1'b1;
            if (last_stop) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          tx_r    <= 1'b1;
          ctr     <= '0;
          bit_ctr <= '0;
        end
      endcase
      if (launch) begin
        state   <= START_BIT;
        shift   <= hold;
        hold    <= '0;
        busy_r  <= 1'b0;
        tx_r    <= 1'b0;
        ctr     <= '0;
        bit_ctr <= '0;
`ifdef SERIAL_TX_PARITY_EN
        par     <= ^hold;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed + randomized checks of serial_tx frames against an arithmetic bit-sequence model
module tb_serial_tx;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  serial_tx_if i0 ();
  serial_tx_if i1 ();
  serial_tx #(.CLK_PER_BIT(CPB), .CTR_SIZE(3), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .s(i0.slave));
  serial_tx #(.CLK_PER_BIT(CPB), .CTR_SIZE(3), .STOP_BITS(2)) dut1 (.clk(clk), .rst(rst), .s(i1.slave));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic tx_of(int s);
    return s != 0 ? i1.tx : i0.tx;
  endfunction
  function automatic logic busy_of(int s);
    return s != 0 ? i1.busy : i0.busy;
  endfunction
  task automatic drive(int s, logic nd, logic [7:0] d);
    if (s != 0) begin i1.new_data = nd; i1.data = d; end
    else begin i0.new_data = nd; i0.data = d; end
  endtask
  task automatic blk(int s, logic v);
    if (s != 0) i1.block = v; else i0.block = v;
  endtask
  task automatic write(int s, logic [7:0] d);
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, 8'h00);
    chk("busy_after_write", busy_of(s), 1'b1);
    @(negedge clk);
  endtask
  function automatic logic exp_bit(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction
  task automatic frame_check(int s, logic [7:0] b, int nstop, bit nxt_v, logic [7:0] nxt, bit junk, bit tog);
    int nb;
    int t;
    nb = 9 + PAR + nstop;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < CPB; c++) begin
        t = k * CPB + c;
        chk("tx_bit", tx_of(s), exp_bit(b, k));
        if (t == 1) chk("busy_in_frame", busy_of(s), nxt_v);
        drive(s, 1'b0, 8'h00);
        if (t == 0 && nxt_v) drive(s, 1'b1, nxt);
        if (t == 8 && junk && nxt_v) drive(s, 1'b1, 8'($urandom));
        if (tog && t == 10) blk(s, 1'b1);
        if (tog && t == 30) blk(s, 1'b0);
        @(negedge clk);
      end
    end
    drive(s, 1'b0, 8'h00);
  endtask
  task automatic idle_check(int s, int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", tx_of(s), 1'b1);
      chk("idle_busy", busy_of(s), 1'b0);
      @(negedge clk);
    end
  endtask
  initial begin
    logic [7:0] q [$];
    i0.block = 1'b0; i0.new_data = 1'b0; i0.data = 8'h00;
    i1.block = 1'b0; i1.new_data = 1'b0; i1.data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_tx", i0.tx, 1'b1);
    chk("reset_busy", i0.busy, 1'b0);
    idle_check(0, 3);
    write(0, 8'h55);
    frame_check(0, 8'h55, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check(0, 5);
    write(0, 8'hA5);
    frame_check(0, 8'hA5, 1, 1'b1, 8'h3C, 1'b1, 1'b0);
    frame_check(0, 8'h3C, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check(0, 60);
    blk(0, 1'b1);
    write(0, 8'h81);
    for (int i = 0; i < 99; i++) begin
      chk("blocked_tx", i0.tx, 1'b1);
      chk("blocked_busy", i0.busy, 1'b1);
      @(negedge clk);
    end
    blk(0, 1'b0);
    @(negedge clk);
    frame_check(0, 8'h81, 1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle_check(0, 4);
    write(0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      chk("pre_reset_tx", i0.tx, 1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midframe_reset_tx", i0.tx, 1'b1);
    chk("midframe_reset_busy", i0.busy, 1'b0);
    idle_check(0, 8);
    write(0, 8'hFF);
    frame_check(0, 8'hFF, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check(0, 50);
    write(1, 8'h12);
    frame_check(1, 8'h12, 2, 1'b1, 8'h34, 1'b0, 1'b0);
    frame_check(1, 8'h34, 2, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check(1, 10);
`ifdef SERIAL_TX_PARITY_EN
    write(0, 8'h07);
    frame_check(0, 8'h07, 1, 1'b1, 8'h03, 1'b0, 1'b0);
    frame_check(0, 8'h03, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_check(0, 5);
`endif
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    write(0, q[0]);
    for (int i = 0; i < 6; i++)
      frame_check(0, q[i], 1, i < 5, i < 5 ? q[i+1] : 8'h00, 1'b1, 1'($urandom));
    idle_check(0, 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
